id_ex_pipe_reg: RTL and testbench

//  ID->EX pipeline register. Captures the forwarded operand values and decoded control of the ID-stage instruction and presents them to EX.

---
 rtl/id_ex_pipe_reg.sv | 133 +++++++++++++
 tb/tb_id_ex_pipe_reg.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe_reg.sv
// ID->EX pipeline register. It detects load-use hazards and inserts a one-cycle bubble for them.
// It also keeps a saturating count of the bubbles inserted for load-use hazards.
module id_ex_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              ex_stall,
  input  logic              id_valid,
  input  logic [4:0]        id_reg_s_addr,
  input  logic [4:0]        id_reg_t_addr,
  input  logic              id_use_s,
  input  logic              id_use_t,
  input  logic [DATA_W-1:0] id_reg_s_value,
  input  logic [DATA_W-1:0] id_reg_t_value,
  input  logic [4:0]        id_reg_dest,
  input  logic [1:0]        id_access_op,
  input  logic [3:0]        id_mem_op,
  input  logic [5:0]        id_alu_op,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0] id_pc,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_reg_s_value,
  output logic [DATA_W-1:0] ex_reg_t_value,
  output logic [4:0]        ex_reg_dest,
  output logic [1:0]        ex_access_op,
  output logic [3:0]        ex_mem_op,
  output logic [5:0]        ex_alu_op,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_pc,
  output logic              load_use_stall,
  output logic [CNT_W-1:0]  bubble_cnt
);

  // Access-op encodings shared with the operand mux (ACCESS_OP_* in defs.v)
  localparam logic [1:0] ACCESS_OP_NOP = 2'b00;
  localparam logic [1:0] ACCESS_OP_M2R = 2'b01;

  logic              valid_q,  valid_d;
  logic [DATA_W-1:0] s_val_q,  s_val_d;
  logic [DATA_W-1:0] t_val_q,  t_val_d;
  logic [4:0]        dest_q,   dest_d;
  logic [1:0]        acc_q,    acc_d;
  logic [3:0]        mem_q,    mem_d;
  logic [5:0]        alu_q,    alu_d;
  logic [DATA_W-1:0] imm_q,    imm_d;
  logic [DATA_W-1:0] pc_q,     pc_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;
  logic              hazard;

  // A load in EX writes its result too late for ID to forward it; $0 never creates a hazard
  assign hazard = id_valid & valid_q & (acc_q == ACCESS_OP_M2R) & (dest_q != 5'd0) &
                  ((id_use_s & (id_reg_s_addr == dest_q)) |
                   (id_use_t & (id_reg_t_addr == dest_q)));

  always_comb begin
    valid_d = valid_q;
    s_val_d = s_val_q;
    t_val_d = t_val_q;
    dest_d  = dest_q;
    acc_d   = acc_q;
    mem_d   = mem_q;
    alu_d   = alu_q;
    imm_d   = imm_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    if (flush || (!ex_stall && hazard)) begin
      valid_d = 1'b0;
      s_val_d = '0;
      t_val_d = '0;
      dest_d  = 5'd0;
      acc_d   = ACCESS_OP_NOP;
      mem_d   = '0;
      alu_d   = '0;
      imm_d   = '0;
      pc_d    = '0;
      // A flush bubble is not a hazard bubble, so only the hazard path counts
      if (!flush && (cnt_q != {CNT_W{1'b1}}))
        cnt_d = cnt_q + 1'b1;
    end else if (!ex_stall) begin
      valid_d = id_valid;
      s_val_d = id_reg_s_value;
      t_val_d = id_reg_t_value;
      dest_d  = id_valid ? id_reg_dest : 5'd0;
      acc_d   = id_valid ? id_access_op : ACCESS_OP_NOP;
      mem_d   = id_mem_op;
      alu_d   = id_alu_op;
      imm_d   = id_imm;
      pc_d    = id_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      s_val_q <= '0;
      t_val_q <= '0;
      dest_q  <= 5'd0;
      acc_q   <= ACCESS_OP_NOP;
      mem_q   <= '0;
      alu_q   <= '0;
      imm_q   <= '0;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      s_val_q <= s_val_d;
      t_val_q <= t_val_d;
      dest_q  <= dest_d;
      acc_q   <= acc_d;
      mem_q   <= mem_d;
      alu_q   <= alu_d;
      imm_q   <= imm_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ex_valid       = valid_q;
  assign ex_reg_s_value = s_val_q;
  assign ex_reg_t_value = t_val_q;
  assign ex_reg_dest    = dest_q;
  assign ex_access_op   = acc_q;
  assign ex_mem_op      = mem_q;
  assign ex_alu_op      = alu_q;
  assign ex_imm         = imm_q;
  assign ex_pc          = pc_q;
  assign load_use_stall = hazard;
  assign bubble_cnt     = cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed bench for id_ex_pipe_reg. A second instance with a 4-bit counter exercises counter saturation.
module tb_id_ex_pipe_reg;

  localparam logic [1:0] NOP = 2'b00;
  localparam logic [1:0] M2R = 2'b01;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush, ex_stall, id_valid, id_use_s, id_use_t;
  logic [4:0]  id_reg_s_addr, id_reg_t_addr, id_reg_dest;
  logic [31:0] id_reg_s_value, id_reg_t_value, id_imm, id_pc;
  logic [1:0]  id_access_op;
  logic [3:0]  id_mem_op;
  logic [5:0]  id_alu_op;

  logic        ex_valid, load_use_stall;
  logic [31:0] ex_reg_s_value, ex_reg_t_value, ex_imm, ex_pc;
  logic [4:0]  ex_reg_dest;
  logic [1:0]  ex_access_op;
  logic [3:0]  ex_mem_op;
  logic [5:0]  ex_alu_op;
  logic [15:0] bubble_cnt;

  logic        s_ex_valid, s_load_use_stall;
  logic [31:0] s_ex_reg_s_value, s_ex_reg_t_value, s_ex_imm, s_ex_pc;
  logic [4:0]  s_ex_reg_dest;
  logic [1:0]  s_ex_access_op;
  logic [3:0]  s_ex_mem_op;
  logic [5:0]  s_ex_alu_op;
  logic [3:0]  s_bubble_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  id_ex_pipe_reg #(.DATA_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .ex_stall(ex_stall), .id_valid(id_valid),
    .id_reg_s_addr(id_reg_s_addr), .id_reg_t_addr(id_reg_t_addr),
    .id_use_s(id_use_s), .id_use_t(id_use_t),
    .id_reg_s_value(id_reg_s_value), .id_reg_t_value(id_reg_t_value),
    .id_reg_dest(id_reg_dest), .id_access_op(id_access_op), .id_mem_op(id_mem_op),
    .id_alu_op(id_alu_op), .id_imm(id_imm), .id_pc(id_pc),
    .ex_valid(ex_valid), .ex_reg_s_value(ex_reg_s_value), .ex_reg_t_value(ex_reg_t_value),
    .ex_reg_dest(ex_reg_dest), .ex_access_op(ex_access_op), .ex_mem_op(ex_mem_op),
    .ex_alu_op(ex_alu_op), .ex_imm(ex_imm), .ex_pc(ex_pc),
    .load_use_stall(load_use_stall), .bubble_cnt(bubble_cnt)
  );

  id_ex_pipe_reg #(.DATA_W(32), .CNT_W(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .flush(flush), .ex_stall(ex_stall), .id_valid(id_valid),
    .id_reg_s_addr(id_reg_s_addr), .id_reg_t_addr(id_reg_t_addr),
    .id_use_s(id_use_s), .id_use_t(id_use_t),
    .id_reg_s_value(id_reg_s_value), .id_reg_t_value(id_reg_t_value),
    .id_reg_dest(id_reg_dest), .id_access_op(id_access_op), .id_mem_op(id_mem_op),
    .id_alu_op(id_alu_op), .id_imm(id_imm), .id_pc(id_pc),
    .ex_valid(s_ex_valid), .ex_reg_s_value(s_ex_reg_s_value), .ex_reg_t_value(s_ex_reg_t_value),
    .ex_reg_dest(s_ex_reg_dest), .ex_access_op(s_ex_access_op), .ex_mem_op(s_ex_mem_op),
    .ex_alu_op(s_ex_alu_op), .ex_imm(s_ex_imm), .ex_pc(s_ex_pc),
    .load_use_stall(s_load_use_stall), .bubble_cnt(s_bubble_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1 ns past it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [1:0] acc, input logic [4:0] dest,
                        input logic us, input logic [4:0] rs, input logic ut,
                        input logic [4:0] rt, input logic [5:0] alu, input logic [31:0] pc);
    id_valid = v; id_access_op = acc; id_reg_dest = dest;
    id_use_s = us; id_reg_s_addr = rs; id_use_t = ut; id_reg_t_addr = rt;
    id_alu_op = alu; id_pc = pc;
    id_reg_s_value = pc ^ 32'h0000_1234;
    id_reg_t_value = pc ^ 32'h0000_5555;
    id_imm = pc + 32'd4;
    id_mem_op = pc[5:2];
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; ex_stall = 1'b0;
    set_id(1'b0, NOP, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 6'h00, 32'h0);
    #12;
    rst_n = 1'b1;
    #1;
    // T1 reset state
    check("rst_valid", ex_valid, 0);
    check("rst_acc", ex_access_op, NOP);
    check("rst_cnt", bubble_cnt, 0);
    check("rst_pc", ex_pc, 0);

    // T2 pass-through
    set_id(1'b1, NOP, 5'd5, 1'b1, 5'd1, 1'b1, 5'd2, 6'h21, 32'h100);
    id_reg_s_value = 32'h1234;
    #1 check("t2_lus_pre", load_use_stall, 0);
    step();
    check("t2_valid", ex_valid, 1);
    check("t2_alu", ex_alu_op, 6'h21);
    check("t2_sval", ex_reg_s_value, 32'h1234);
    check("t2_tval", ex_reg_t_value, 32'h100 ^ 32'h5555);
    check("t2_dest", ex_reg_dest, 5);
    check("t2_imm", ex_imm, 32'h104);
    check("t2_mem", ex_mem_op, 4'h0);
    check("t2_pc", ex_pc, 32'h100);
    check("t2_lus", load_use_stall, 0);

    // T3 load-use on rs
    set_id(1'b1, M2R, 5'd8, 1'b0, 5'd0, 1'b0, 5'd0, 6'h23, 32'h104);
    step();
    check("t3_ld_acc", ex_access_op, M2R);
    check("t3_ld_dest", ex_reg_dest, 8);
    set_id(1'b1, NOP, 5'd9, 1'b1, 5'd8, 1'b0, 5'd0, 6'h22, 32'h108);
    #1 check("t3_lus", load_use_stall, 1);
    step();
    check("t3_bub_valid", ex_valid, 0);
    check("t3_bub_acc", ex_access_op, NOP);
    check("t3_bub_dest", ex_reg_dest, 0);
    check("t3_bub_pc", ex_pc, 0);
    check("t3_cnt", bubble_cnt, 1);
    check("t3_lus_drop", load_use_stall, 0);
    step();
    check("t3_enter_valid", ex_valid, 1);
    check("t3_enter_pc", ex_pc, 32'h108);
    check("t3_enter_dest", ex_reg_dest, 9);

    // T4 load to $0, then unused rt operand
    set_id(1'b1, M2R, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 6'h23, 32'h10c);
    step();
    check("t4_ld0_dest", ex_reg_dest, 0);
    set_id(1'b1, M2R, 5'd8, 1'b1, 5'd0, 1'b0, 5'd0, 6'h23, 32'h110);
    #1 check("t4_zero_lus", load_use_stall, 0);
    step();
    set_id(1'b1, NOP, 5'd10, 1'b1, 5'd3, 1'b1, 5'd8, 6'h20, 32'h114);
    #1 check("t4_rt_used_lus", load_use_stall, 1);
    id_use_t = 1'b0;
    #1 check("t4_rt_unused_lus", load_use_stall, 0);
    step();
    check("t4_pc", ex_pc, 32'h114);
    check("t4_cnt", bubble_cnt, 1);

    // T5 downstream stall holds EX for 3 cycles
    ex_stall = 1'b1;
    set_id(1'b1, NOP, 5'd11, 1'b0, 5'd0, 1'b0, 5'd0, 6'h3f, 32'h200);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t5_hold_pc", ex_pc, 32'h114);
      check("t5_hold_alu", ex_alu_op, 6'h20);
    end
    ex_stall = 1'b0;
    step();
    check("t5_rel_pc", ex_pc, 32'h200);
    check("t5_rel_alu", ex_alu_op, 6'h3f);
    check("t5_rel_dest", ex_reg_dest, 11);

    // Invalid ID instruction forces NOP and dest 0
    set_id(1'b0, M2R, 5'd12, 1'b0, 5'd0, 1'b0, 5'd0, 6'h01, 32'h204);
    step();
    check("inv_valid", ex_valid, 0);
    check("inv_acc", ex_access_op, NOP);
    check("inv_dest", ex_reg_dest, 0);

    // T6 flush together with load-use
    set_id(1'b1, M2R, 5'd8, 1'b0, 5'd0, 1'b0, 5'd0, 6'h23, 32'h300);
    step();
    set_id(1'b1, NOP, 5'd13, 1'b1, 5'd8, 1'b0, 5'd0, 6'h20, 32'h304);
    flush = 1'b1;
    #1 check("t6_lus", load_use_stall, 1);
    step();
    flush = 1'b0;
    check("t6_valid", ex_valid, 0);
    check("t6_acc", ex_access_op, NOP);
    check("t6_cnt", bubble_cnt, 1);

    // Stall with a held load in EX: hazard still visible, counter held
    set_id(1'b1, M2R, 5'd8, 1'b0, 5'd0, 1'b0, 5'd0, 6'h23, 32'h308);
    step();
    set_id(1'b1, NOP, 5'd14, 1'b0, 5'd0, 1'b1, 5'd8, 6'h20, 32'h30c);
    ex_stall = 1'b1;
    step();
    check("stl_lus", load_use_stall, 1);
    check("stl_cnt", bubble_cnt, 1);
    check("stl_pc", ex_pc, 32'h308);
    ex_stall = 1'b0;

    // Async reset in the middle of a load-use stall
    #2 rst_n = 1'b0;
    #1;
    check("ar_lus", load_use_stall, 0);
    check("ar_valid", ex_valid, 0);
    check("ar_cnt", bubble_cnt, 0);
    check("ar_pc", ex_pc, 0);
    #3 rst_n = 1'b1;

    // Back-to-back dependent loads: one bubble every two cycles
    set_id(1'b1, M2R, 5'd8, 1'b1, 5'd8, 1'b0, 5'd0, 6'h23, 32'h400);
    step();
    check("sat_first_acc", ex_access_op, M2R);
    for (int i = 0; i < 15; i++) begin
      step();
      step();
    end
    check("sat_cnt15", bubble_cnt, 15);
    check("sat_small15", s_bubble_cnt, 4'hf);
    for (int i = 0; i < 5; i++) begin
      step();
      step();
    end
    check("sat_cnt20", bubble_cnt, 20);
    check("sat_small_hold", s_bubble_cnt, 4'hf);
    check("sat_small_valid", s_ex_valid, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
